// File: rtl/apple_shadow_write_queue.sv
// Shadow-memory write queue: qualifies Apple II bus writes, maps them to SDRAM
// words/byte lanes, and buffers them (with optional tail merging) for the arbiter.
module apple_shadow_write_queue #(
  parameter int          ADDR_WIDTH  = 21,
  parameter int          NUM_BANKS   = 2,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [3:0]  REGION_MASK = 4'b0011,
  parameter bit          COALESCE    = 1'b1,
  localparam int         BANK_BITS   = (NUM_BANKS <= 2) ? 1 : $clog2(NUM_BANKS),
  localparam int         PTR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_logic,
  input  logic                  system_reset,
  input  logic [15:0]           bus_addr,
  input  logic [7:0]            bus_data,
  input  logic                  bus_rw_n,
  input  logic                  bus_strobe,
  input  logic                  bus_m2sel_n,
  input  logic [BANK_BITS-1:0]  bank_i,
  input  logic                  clear_overflow_i,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic [3:0]            mem_byte_en,
  input  logic                  mem_ready,
  output logic [PTR_W:0]        fifo_level,
  output logic                  overflow_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            be;
  } entry_t;

  entry_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [PTR_W:0]     level_q, level_d;
  logic               ovf_q, ovf_d;

  logic [3:0]            region;
  logic                  bank_ok, qual, pop, full, merge, push, drop;
  logic [1:0]            lane;
  logic [3:0]            new_be;
  logic [ADDR_WIDTH-1:0] upper, new_addr;

  always_comb begin
    region[0] = (bus_addr >= 16'h0400) && (bus_addr <= 16'h0BFF);
    region[1] = (bus_addr >= 16'h2000) && (bus_addr <= 16'h5FFF);
    region[2] = (bus_addr >= 16'h6000) && (bus_addr <= 16'h9FFF);
    region[3] = ~|region[2:0];
    bank_ok   = int'(bank_i) < NUM_BANKS;
    qual      = bus_strobe && !bus_rw_n && !bus_m2sel_n && (|(REGION_MASK & region)) && bank_ok;

    lane      = {bus_addr[0], bank_i[0]};
    new_be    = 4'b0001 << lane;
    // bank bit 0 selects the byte lane, so only the upper bank bits land in the address
    upper     = ADDR_WIDTH'(bank_i) >> 1;
    new_addr  = (upper << 15) | ADDR_WIDTH'(bus_addr[15:1]);

    tail_ptr  = wr_ptr_q - 1'b1;
    pop       = (level_q != '0) && mem_ready;
    full      = level_q == (PTR_W+1)'(FIFO_DEPTH);
    // level >= 2 keeps the head (being presented) out of any merge
    merge     = COALESCE && qual && (level_q >= (PTR_W+1)'(2)) && (fifo_q[tail_ptr].addr == new_addr);
    push      = qual && !merge && (!full || pop);
    drop      = qual && !merge && full && !pop;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    ovf_d = ovf_q;
    if (drop)                  ovf_d = 1'b1;
    else if (clear_overflow_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (merge) begin
        for (int k = 0; k < 4; k++)
          if (new_be[k]) fifo_q[tail_ptr].data[8*k +: 8] <= bus_data;
        fifo_q[tail_ptr].be <= fifo_q[tail_ptr].be | new_be;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= '{addr: new_addr, data: {4{bus_data}}, be: new_be};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_wr      = level_q != '0;
  assign mem_addr    = fifo_q[rd_ptr_q].addr;
  assign mem_data    = fifo_q[rd_ptr_q].data;
  assign mem_byte_en = fifo_q[rd_ptr_q].be;
  assign fifo_level  = level_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_apple_shadow_write_queue.sv
// Directed + random bench for two queue configurations, checked against a queue model.
module tb_apple_shadow_write_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic        strobe = 1'b0, rw_n = 1'b1, m2sel_n = 1'b0;
  logic [15:0] baddr = '0;
  logic [7:0]  bdata = '0;
  logic [1:0]  bank = '0;

  logic        wr0, wr1, ov0, ov1;
  logic [20:0] ad0, ad1;
  logic [31:0] dt0, dt1;
  logic [3:0]  be0, be1, lv0;
  logic [2:0]  lv1;

  always #5 clk = ~clk;

  apple_shadow_write_queue u0 (
    .clk_logic(clk), .system_reset(rst), .bus_addr(baddr), .bus_data(bdata),
    .bus_rw_n(rw_n), .bus_strobe(strobe), .bus_m2sel_n(m2sel_n), .bank_i(bank[0:0]),
    .clear_overflow_i(clr), .mem_wr(wr0), .mem_addr(ad0), .mem_data(dt0),
    .mem_byte_en(be0), .mem_ready(rdy), .fifo_level(lv0), .overflow_o(ov0));

  apple_shadow_write_queue #(.ADDR_WIDTH(21), .NUM_BANKS(3), .FIFO_DEPTH(4),
                             .REGION_MASK(4'b0101), .COALESCE(1'b0)) u1 (
    .clk_logic(clk), .system_reset(rst), .bus_addr(baddr), .bus_data(bdata),
    .bus_rw_n(rw_n), .bus_strobe(strobe), .bus_m2sel_n(m2sel_n), .bank_i(bank),
    .clear_overflow_i(clr), .mem_wr(wr1), .mem_addr(ad1), .mem_data(dt1),
    .mem_byte_en(be1), .mem_ready(rdy), .fifo_level(lv1), .overflow_o(ov1));

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned be;
  } ment_t;

  ment_t mq [2][$];
  bit    movf [2];
  bit    clean [2];
  int    MASK [2] = '{3, 5};
  int    NB   [2] = '{2, 3};
  int    COAL [2] = '{1, 0};
  int    DEP  [2] = '{8, 4};

  int n_cmp = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int d);
    int unsigned b, a, r, lane;
    bit pop, qual, set;
    ment_t e, t;
    if (rst) begin
      mq[d].delete();
      movf[d]  = 1'b0;
      clean[d] = 1'b1;
      return;
    end
    pop = (mq[d].size() > 0) && rdy;
    b   = (d == 0) ? int'(bank[0]) : int'(bank);
    a   = int'(baddr);
    if (a >= 'h0400 && a <= 'h0BFF)      r = 0;
    else if (a >= 'h2000 && a <= 'h5FFF) r = 1;
    else if (a >= 'h6000 && a <= 'h9FFF) r = 2;
    else                                 r = 3;
    qual = strobe && !rw_n && !m2sel_n && ((MASK[d] >> r) & 1) != 0 && b < NB[d];
    set  = 1'b0;
    if (qual) begin
      e.addr = (b / 2) * 32768 + a / 2;
      lane   = (a % 2) * 2 + (b % 2);
      e.be   = 1 << lane;
      e.data = int'(bdata) * 32'h01010101;
      if (COAL[d] != 0 && mq[d].size() >= 2 && mq[d][mq[d].size()-1].addr == e.addr) begin
        t = mq[d][mq[d].size()-1];
        t.data = (t.data & ~(32'hFF << (8 * lane))) | (int'(bdata) << (8 * lane));
        t.be   = t.be | e.be;
        mq[d][mq[d].size()-1] = t;
      end else if (mq[d].size() < DEP[d] || pop) begin
        mq[d].push_back(e);
        clean[d] = 1'b0;
      end else begin
        set = 1'b1;
      end
    end
    if (set)      movf[d] = 1'b1;
    else if (clr) movf[d] = 1'b0;
    if (pop) void'(mq[d].pop_front());
  endtask

  task automatic cmp_dut(int d, logic wr, logic [20:0] ad, logic [31:0] dt,
                         logic [3:0] be, logic [3:0] lv, logic ov);
    string p;
    p = $sformatf("u%0d", d);
    chk({p, ".mem_wr"}, 64'(wr), 64'(mq[d].size() > 0));
    chk({p, ".level"},  64'(lv), 64'(mq[d].size()));
    chk({p, ".ovf"},    64'(ov), 64'(movf[d]));
    if (mq[d].size() > 0) begin
      chk({p, ".addr"}, 64'(ad), 64'(mq[d][0].addr));
      chk({p, ".data"}, 64'(dt), 64'(mq[d][0].data));
      chk({p, ".be"},   64'(be), 64'(mq[d][0].be));
    end else if (clean[d]) begin
      chk({p, ".addr0"}, 64'(ad), 64'd0);
      chk({p, ".data0"}, 64'(dt), 64'd0);
      chk({p, ".be0"},   64'(be), 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    cmp_dut(0, wr0, ad0, dt0, be0, lv0, ov0);
    cmp_dut(1, wr1, ad1, dt1, be1, {1'b0, lv1}, ov1);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] dv, logic [1:0] b);
    baddr = a; bdata = dv; bank = b; strobe = 1'b1; rw_n = 1'b0;
    tick();
    strobe = 1'b0; rw_n = 1'b1;
  endtask

  logic [15:0] pool [8] = '{16'h0400, 16'h0401, 16'h2000, 16'h2001,
                            16'h6000, 16'h9FFF, 16'h0C00, 16'h0BFF};

  initial begin
    // reset state
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_wr", 64'(wr0), 0); chk("rst_lvl", 64'(lv0), 0); chk("rst_ovf", 64'(ov0), 0);
    chk("rst_addr", 64'(ad0), 0); chk("rst_data", 64'(dt0), 0); chk("rst_be", 64'(be0), 0);

    // single write, next-cycle presentation, pop
    wr(16'h2000, 8'hAA, 2'd0);
    chk("w1_wr", 64'(wr0), 1); chk("w1_addr", 64'(ad0), 64'h1000);
    chk("w1_be", 64'(be0), 64'h1); chk("w1_data", 64'(dt0), 64'hAAAAAAAA);
    rdy = 1'b1; tick(); rdy = 1'b0;
    chk("w1_pop_wr", 64'(wr0), 0); chk("w1_pop_lvl", 64'(lv0), 0);

    // merge into tail, head untouched
    wr(16'h0401, 8'h11, 2'd0); wr(16'h0401, 8'h22, 2'd1); wr(16'h0400, 8'h33, 2'd1);
    chk("m_lvl", 64'(lv0), 2); chk("m_head_addr", 64'(ad0), 64'h200); chk("m_head_be", 64'(be0), 64'b0100);
    rdy = 1'b1; tick(); rdy = 1'b0;
    chk("m_tail_be", 64'(be0), 64'b1010); chk("m_tail_data", 64'(dt0), 64'h22223322);
    rdy = 1'b1; repeat (5) tick(); rdy = 1'b0;

    // full / overflow / set-beats-clear / push-with-pop / merge-at-full
    for (int i = 0; i < 8; i++) wr(16'h2000 + 16'(2 * i), 8'(i), 2'd0);
    chk("f_lvl8", 64'(lv0), 8); chk("f_ovf0", 64'(ov0), 0);
    wr(16'h3000, 8'h99, 2'd0);
    chk("f_drop_lvl", 64'(lv0), 8); chk("f_drop_ovf", 64'(ov0), 1);
    clr = 1'b1; wr(16'h3002, 8'h98, 2'd0);
    chk("f_set_wins", 64'(ov0), 1);
    tick(); clr = 1'b0;
    chk("f_clr", 64'(ov0), 0);
    rdy = 1'b1; wr(16'h3004, 8'h97, 2'd0); rdy = 1'b0;
    chk("f_pushpop_lvl", 64'(lv0), 8); chk("f_pushpop_ovf", 64'(ov0), 0);
    wr(16'h3005, 8'h96, 2'd0);
    chk("f_merge_lvl", 64'(lv0), 8); chk("f_merge_ovf", 64'(ov0), 0);
    rdy = 1'b1; repeat (10) tick(); rdy = 1'b0;

    // region mask / bank limit / mapping on u1
    rst = 1'b1; tick(); rst = 1'b0;
    wr(16'h2000, 8'h01, 2'd0); wr(16'h0BFF, 8'h02, 2'd0); wr(16'h0C00, 8'h03, 2'd0);
    m2sel_n = 1'b1; wr(16'h0400, 8'h04, 2'd0); m2sel_n = 1'b0;
    chk("r_lvl", 64'(lv1), 1); chk("r_addr", 64'(ad1), 64'h5FF); chk("r_be", 64'(be1), 64'b0100);
    rdy = 1'b1; tick(); rdy = 1'b0;
    wr(16'h9FFF, 8'h05, 2'd2);
    chk("b_addr", 64'(ad1), 64'hCFFF); chk("b_be", 64'(be1), 64'b0100);
    wr(16'h9FFF, 8'h06, 2'd3);
    chk("b_ign_lvl", 64'(lv1), 1);
    rdy = 1'b1; repeat (10) tick(); rdy = 1'b0;

    // reset mid-handshake
    wr(16'h2000, 8'h10, 2'd0); wr(16'h2002, 8'h11, 2'd0); wr(16'h2004, 8'h12, 2'd0);
    chk("x_pre_lvl", 64'(lv0), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("x_wr", 64'(wr0), 0); chk("x_lvl", 64'(lv0), 0); chk("x_ovf", 64'(ov0), 0);
    wr(16'h2100, 8'h13, 2'd0);
    chk("x_new_wr", 64'(wr0), 1); chk("x_new_addr", 64'(ad0), 64'h1080);
    rdy = 1'b1; repeat (10) tick(); rdy = 1'b0;

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 63) == 0);
      rdy     = ($urandom_range(0, 9) < 4);
      clr     = ($urandom_range(0, 9) == 0);
      strobe  = ($urandom_range(0, 9) < 8);
      rw_n    = ($urandom_range(0, 9) == 0);
      m2sel_n = ($urandom_range(0, 9) == 0);
      bank    = 2'($urandom_range(0, 3));
      bdata   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) baddr = baddr ^ 16'h0001;
      else if ($urandom_range(0, 4) == 0) baddr = 16'($urandom);
      else baddr = pool[$urandom_range(0, 7)];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
